// File: rtl/fft_bitrev_reorder.sv
// fft_bitrev_reorder: output-side reorder buffer for the R2SDF FFT pipeline.
// Frames arrive in bit-reversed index order. Each frame is written into one
// half of a ping-pong buffer, then read back in natural order as a contiguous
// N-cycle burst while the next frame fills the other half.
// Optional feature macro: FFT_REORDER_LAST_EN adds the do_last frame marker.
// Sample width comes from the DATA_IN_WIDTH macro (16 when not defined).

`ifndef DATA_IN_WIDTH
`define DATA_IN_WIDTH 16
`endif

module fft_bitrev_reorder #(
  parameter int unsigned LOG_N = 6
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      di_en,
  input  logic [`DATA_IN_WIDTH-1:0] di_re,
  input  logic [`DATA_IN_WIDTH-1:0] di_im,
  output logic                      do_en,
  output logic [`DATA_IN_WIDTH-1:0] do_re,
  output logic [`DATA_IN_WIDTH-1:0] do_im
`ifdef FFT_REORDER_LAST_EN
  ,
  output logic                      do_last
`endif
);

  localparam int unsigned W = `DATA_IN_WIDTH;
  localparam int unsigned N = 1 << LOG_N;
  localparam logic [LOG_N-1:0] CNT_MAX = LOG_N'(N - 1);

  typedef enum logic {
    IDLE,
    READ
  } state_e;

  // Mirror the index bits: position in the arriving frame -> natural index.
  function automatic logic [LOG_N-1:0] bitrev(input logic [LOG_N-1:0] a);
    logic [LOG_N-1:0] r;
    r = '0;
    for (int i = 0; i < int'(LOG_N); i++) begin
      r[i] = a[int'(LOG_N) - 1 - i];
    end
    return r;
  endfunction

  // Ping-pong storage, two banks of N complex words; deliberately unreset.
  logic [2*W-1:0] mem_q [2][N];

  logic [LOG_N-1:0] wr_cnt_q, wr_cnt_d;
  logic             wr_bank_q, wr_bank_d;
  logic             start_c;

  state_e           state_q, state_d;
  logic [LOG_N-1:0] rd_cnt_q, rd_cnt_d;
  logic             rd_bank_q, rd_bank_d;

  logic             do_en_q, do_en_d;
  logic [W-1:0]     do_re_q, do_re_d;
  logic [W-1:0]     do_im_q, do_im_d;
`ifdef FFT_REORDER_LAST_EN
  logic             do_last_q, do_last_d;
`endif

  // A frame completes on the valid edge that carries its last sample.
  assign start_c = di_en && (wr_cnt_q == CNT_MAX);

  // Write-side counter and bank select; gaps simply hold the state.
  always_comb begin
    wr_cnt_d  = wr_cnt_q;
    wr_bank_d = wr_bank_q;
    if (di_en) begin
      wr_cnt_d = wr_cnt_q + LOG_N'(1);
      if (start_c) begin
        wr_bank_d = ~wr_bank_q;
      end
    end
  end

  // Write-side state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_cnt_q  <= '0;
      wr_bank_q <= 1'b0;
    end else begin
      wr_cnt_q  <= wr_cnt_d;
      wr_bank_q <= wr_bank_d;
    end
  end

  // Store each sample at its natural-order address.
  always_ff @(posedge clk) begin
    if (di_en) begin
      mem_q[wr_bank_q][bitrev(wr_cnt_q)] <= {di_re, di_im};
    end
  end

  // Read FSM: next state, read pointer and next output values.
  always_comb begin
    state_d   = state_q;
    rd_cnt_d  = rd_cnt_q;
    rd_bank_d = rd_bank_q;
    do_en_d   = 1'b0;
    do_re_d   = '0;
    do_im_d   = '0;
`ifdef FFT_REORDER_LAST_EN
    do_last_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (start_c) begin
          state_d   = READ;
          rd_bank_d = wr_bank_q;
          rd_cnt_d  = '0;
        end
      end
      READ: begin
        do_en_d            = 1'b1;
        {do_re_d, do_im_d} = mem_q[rd_bank_q][rd_cnt_q];
        rd_cnt_d           = rd_cnt_q + LOG_N'(1);
        if (rd_cnt_q == CNT_MAX) begin
`ifdef FFT_REORDER_LAST_EN
          do_last_d = 1'b1;
`endif
          // A frame completing on the final read edge chains straight on.
          if (start_c) begin
            rd_bank_d = wr_bank_q;
            rd_cnt_d  = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Read FSM state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      rd_cnt_q  <= '0;
      rd_bank_q <= 1'b0;
      do_en_q   <= 1'b0;
      do_re_q   <= '0;
      do_im_q   <= '0;
`ifdef FFT_REORDER_LAST_EN
      do_last_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      rd_cnt_q  <= rd_cnt_d;
      rd_bank_q <= rd_bank_d;
      do_en_q   <= do_en_d;
      do_re_q   <= do_re_d;
      do_im_q   <= do_im_d;
`ifdef FFT_REORDER_LAST_EN
      do_last_q <= do_last_d;
`endif
    end
  end

  assign do_en = do_en_q;
  assign do_re = do_re_q;
  assign do_im = do_im_q;
`ifdef FFT_REORDER_LAST_EN
  assign do_last = do_last_q;
`endif

endmodule

// File: doc/fft_bitrev_reorder.md
# fft_bitrev_reorder

Output-side reorder buffer for the R2SDF FFT pipeline. The last SDF stage emits each N-point frame in bit-reversed index order. This block writes each frame into one half of a ping-pong buffer at bit-reversed addresses. It then reads the frame back in natural order as a contiguous N-cycle burst, while the next frame fills the other half. It is the consumer at the far end of the delay-line/butterfly chain, and the only place in the pipeline where sample order is restored.

## Interface
- LOG_N, default 6: log2 of the frame length N; N = 2^LOG_N points per frame.
- clk  in  1  master clock; all logic on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- di_en  in  1  input sample valid; frames may contain gaps.
- di_re  in  `DATA_IN_WIDTH`  input sample, real part, in bit-reversed index order.
- di_im  in  `DATA_IN_WIDTH`  input sample, imaginary part.
- do_en  out  1  output sample valid; high for exactly N consecutive cycles per frame.
- do_re  out  `DATA_IN_WIDTH`  output sample, real part, in natural index order.
- do_im  out  `DATA_IN_WIDTH`  output sample, imaginary part.
- do_last  out  1  present only with `FFT_REORDER_LAST_EN`; high together with the sample at index N-1.

## Operation
- Storage: 2 banks × N words × 2·`DATA_IN_WIDTH` bits, held in a register array. No reset is applied to the storage.
- Write side:
  - wr_cnt is LOG_N bits and wr_bank is 1 bit.
  - On a clk edge with di_en=1: mem[wr_bank][bitrev(wr_cnt)] <= {di_re, di_im}, and wr_cnt increments.
  - When wr_cnt == N-1 on a di_en edge: wr_cnt wraps to 0, wr_bank toggles, and a start pulse for bank (old wr_bank) is issued to the read side.
  - di_en=0 holds wr_cnt and wr_bank. Gaps of any length inside a frame are legal.
- Read side FSM, with states IDLE and READ:
  - IDLE: when the start pulse arrives, move to READ with rd_bank = the completed bank and rd_cnt = 0.
  - READ: each edge registers mem[rd_bank][rd_cnt] onto do_re/do_im, drives do_en=1, and increments rd_cnt. After the edge that outputs rd_cnt == N-1:
    - if a new start pulse arrives on that same edge, go straight to READ on the other bank with rd_cnt = 0, so the two bursts are back to back;
    - otherwise return to IDLE.
- No overflow is possible. A frame needs at least N write edges, and reading it takes exactly N edges, so the read of bank b always ends before bank b is written again.
- When do_en=0, do_re and do_im are driven 0.
- Frame ordering is preserved: frames come out in the order they were completed.

## Timing
- Reset values: do_en=0, do_re=0, do_im=0, do_last=0, wr_cnt=0, wr_bank=0, rd_cnt=0, FSM=IDLE.
- Latency: if the last sample of a frame is presented in cycle c, natural index 0 appears on do_* in cycle c+2 and index N-1 in cycle c+N+1.
- With continuous input (di_en held at 1), do_en also stays at 1 continuously from the first burst onward.
- Reset mid-operation: rst_n low immediately forces all outputs and state to their reset values. A partial frame being written and any burst in progress are discarded. The first frame after reset release writes into bank 0.
- A start pulse that coincides with the final read edge is never lost; it is handled as described under Operation.

## Configuration
- `FFT_REORDER_LAST_EN` defined:
  - the do_last port exists;
  - do_last is registered and is high exactly in the cycle that carries rd_cnt == N-1, otherwise 0;
  - reset value of do_last is 0.
- `FFT_REORDER_LAST_EN` undefined: the port and its logic are absent, and all other behaviour is identical.

## Test plan
- Order restore (LOG_N=3):
  - Stimulus: di_en=1 for 8 cycles, with di_re = 0,4,2,6,1,5,3,7 and di_im = 10× the same values.
  - Response: do_re = 0..7 and do_im = 0,10,…,70, starting 2 cycles after the last input, with do_en high for exactly 8 cycles.
- Back-to-back frames:
  - Stimulus: 4 frames with continuous di_en.
  - Response: do_en high for an unbroken run of 32 cycles, with each frame's values in natural order and frames in input order.
- Gapped input:
  - Stimulus: the same frame with di_en toggled 1,0,1,0,….
  - Response: identical output values; the burst still lasts exactly 8 contiguous cycles and starts 2 cycles after the last valid input.
- Reset mid-frame:
  - Stimulus: 5 samples, then rst_n low for 1 cycle, then a full fresh frame.
  - Response: outputs are 0 during reset, and only the fresh frame appears, correctly ordered from bank 0.
- Reset mid-burst:
  - Stimulus: assert rst_n at the 3rd output cycle.
  - Response: do_en, do_re and do_im go to 0 immediately, and no remaining samples are emitted.
- do_last (with `FFT_REORDER_LAST_EN`):
  - Stimulus: two back-to-back frames.
  - Response: do_last high only in the cycles carrying index 7, i.e. output cycles 8 and 16.
